ysyx_24100005_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_24100005_mem_arbiter
// PURPOSE
//  Shares the single data-memory port between the instruction fetch unit (IFU) and the
//  load/store unit (LSU) for the multi-cycle NPC core.
//  Arbitrates requests, sequences one outstanding transaction at a time and routes the
//  response back to its owner.
//  A timeout watchdog terminates a stalled transaction with an error response.
// PARAMETERS
//  ADDR_W     32   address width
//  DATA_W     32   data width
//  TIMEOUT    64   max cycles in RESP before error termination (>=2)
// PORTS
//  clk             in   1       clock, all logic on posedge
//  rst             in   1       synchronous reset, active-high
//  ifu_req_valid   in   1       IFU read request
//  ifu_req_ready   out  1       IFU request accepted this cycle
//  ifu_addr        in   ADDR_W  IFU read address
//  ifu_resp_valid  out  1       1-cycle pulse: IFU response on resp_rdata/resp_err
//  lsu_req_valid   in   1       LSU request
//  lsu_req_ready   out  1       LSU request accepted this cycle
//  lsu_addr        in   ADDR_W  LSU address
//  lsu_wen         in   1       1=store, 0=load
//  lsu_wdata       in   DATA_W  store data
//  lsu_wmask       in   8       byte write mask (passed through unchanged)
//  lsu_resp_valid  out  1       1-cycle pulse: LSU response on resp_rdata/resp_err
//  resp_rdata      out  DATA_W  shared response data (valid with either resp pulse)
//  resp_err        out  1       shared error flag (timeout), valid with either resp pulse
//  mem_req_valid   out  1       request to memory
//  mem_req_ready   in   1       memory accepts request
//  mem_addr        out  ADDR_W  registered address
//  mem_wen         out  1       registered write enable (0 for IFU)
//  mem_wdata       out  DATA_W  registered write data (0 for IFU)
//  mem_wmask       out  8       registered mask (0 for IFU)
//  mem_resp_valid  in   1       memory response (read data or write ack)
//  mem_rdata       in   DATA_W  memory read data
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; rr pointer = LSU; timeout counter 0.
//    Reset mid-transaction aborts it; no response is returned to the owner.
//  - States: IDLE -> REQ -> RESP -> IDLE.
//  - IDLE: the granted requester's *_req_ready = 1 combinationally; the other ready = 0.
//    Only one requester valid: it is granted.
//    Both valid: grant = rr pointer; after a grant, pointer = the other requester.
//    On the accept cycle, latch owner/addr/wen/wdata/wmask and go to REQ.
//    All req_ready = 0 outside IDLE.
//  - REQ: mem_req_valid = 1 with latched fields held stable.
//    On mem_req_ready = 1: drop mem_req_valid next cycle, clear counter, go to RESP.
//  - RESP: counter increments each cycle.
//    mem_resp_valid = 1: register resp_rdata = mem_rdata (0 for stores), resp_err = 0,
//    pulse owner's *_resp_valid for exactly 1 cycle (cycle after mem_resp_valid), go to IDLE.
//    Counter reaches TIMEOUT-1 without a response: same pulse with resp_rdata = 0,
//    resp_err = 1, go to IDLE.
//  - mem_resp_valid outside RESP (late or stale) is ignored.
//  - Response arriving on the same cycle as the timeout: the response wins (resp_err = 0).
//  - resp_rdata/resp_err hold their value until the next response.
//  - Min latency, accept to resp pulse, with mem_req_ready=1 and 1-cycle memory: 3 cycles.
//  - Back-to-back: a new accept is possible in the same cycle as the resp pulse (state is IDLE).
// TESTING
//  1. IFU only, addr 0x8000_0000, ready=1, mem_rdata 0x0010_0093 next cycle ->
//     mem_addr=0x8000_0000, mem_wen=0; ifu_resp_valid pulse, resp_rdata=0x0010_0093.
//  2. IFU+LSU valid together for 4 transactions ->
//     grants LSU, IFU, LSU, IFU; lsu_resp_valid never asserted for IFU transactions.
//  3. LSU store addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F, mem_req_ready low 3 cycles ->
//     mem_* held stable, single request; lsu_resp_valid pulse, resp_rdata=0.
//  4. No mem_resp_valid for TIMEOUT=64 cycles ->
//     owner resp pulse, resp_err=1, resp_rdata=0; late mem_resp_valid then ignored.
//  5. rst=1 while in RESP -> next cycle all outputs 0, state IDLE, no resp pulse;
//     following IFU request served normally.

Source files
------------

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares one data-memory port between the IFU and LSU: round-robin arbitration,
// one outstanding transaction, response routed to its owner, timeout watchdog.
module ysyx_24100005_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                rr_lsu_q, rr_lsu_d;
  logic                owner_lsu_q, owner_lsu_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ifu_rv_q, ifu_rv_d;
  logic                lsu_rv_q, lsu_rv_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                grant_ifu, grant_lsu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_lsu_q    <= 1'b1;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      ifu_rv_q    <= 1'b0;
      lsu_rv_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_lsu_q    <= rr_lsu_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      ifu_rv_q    <= ifu_rv_d;
      lsu_rv_q    <= lsu_rv_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_lsu_d    = rr_lsu_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    ifu_rv_d    = 1'b0;
    lsu_rv_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    grant_ifu   = 1'b0;
    grant_lsu   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // rr_lsu_q only matters when both requesters are valid
        grant_lsu = lsu_req_valid && (!ifu_req_valid || rr_lsu_q);
        grant_ifu = ifu_req_valid && !grant_lsu;
        if (grant_lsu) begin
          owner_lsu_d = 1'b1;
          addr_d      = lsu_addr;
          wen_d       = lsu_wen;
          wdata_d     = lsu_wdata;
          wmask_d     = lsu_wmask;
          rr_lsu_d    = 1'b0;
          state_d     = S_REQ;
        end else if (grant_ifu) begin
          owner_lsu_d = 1'b0;
          addr_d      = ifu_addr;
          wen_d       = 1'b0;
          wdata_d     = '0;
          wmask_d     = '0;
          rr_lsu_d    = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // A response in the final watchdog cycle still counts as success
        if (mem_resp_valid) begin
          rdata_d  = wen_q ? '0 : mem_rdata;
          err_d    = 1'b0;
          ifu_rv_d = !owner_lsu_q;
          lsu_rv_d = owner_lsu_q;
          state_d  = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d  = '0;
          err_d    = 1'b1;
          ifu_rv_d = !owner_lsu_q;
          lsu_rv_d = owner_lsu_q;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = ifu_rv_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: vector table plus a
// response scoreboard, with hand-written reset-abort and timeout sequences.
module tb_ysyx_24100005_mem_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic        lv;
    logic [31:0] iaddr;
    logic [31:0] laddr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic [7:0]  stall;      // cycles mem_req_ready held low
    logic [7:0]  lat;        // RESP cycles before the response; >= TIMEOUT means none
    logic [31:0] rdata;
    logic        exp_lsu;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic next_neg();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard consumer: every response pulse must match the oldest accepted request
  always @(negedge clk) begin
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_lsu_valid", {63'd0, lsu_resp_valid}, {63'd0, e.lsu});
        chk("resp_ifu_valid", {63'd0, ifu_resp_valid}, {63'd0, !e.lsu});
        chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
        chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
        $display("resp: owner=%s rdata=0x%08h err=%0d", e.lsu ? "LSU" : "IFU", resp_rdata, resp_err);
      end
    end
  end

  task automatic check_req_fields(input vec_t v);
    chk("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("mem_addr", {32'd0, mem_addr}, {32'd0, v.exp_lsu ? v.laddr : v.iaddr});
    chk("mem_wen", {63'd0, mem_wen}, {63'd0, v.exp_lsu & v.wen});
    chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.exp_lsu ? v.wdata : 32'd0});
    chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, v.exp_lsu ? v.wmask : 8'd0});
  endtask

  // Drive requests in IDLE, check the grant, push the expectation, move to REQ
  task automatic accept(input vec_t v);
    exp_t e;
    ifu_req_valid = v.iv;  ifu_addr = v.iaddr;
    lsu_req_valid = v.lv;  lsu_addr = v.laddr;
    lsu_wen = v.wen;  lsu_wdata = v.wdata;  lsu_wmask = v.wmask;
    #1;
    chk("ifu_req_ready", {63'd0, ifu_req_ready}, {63'd0, !v.exp_lsu});
    chk("lsu_req_ready", {63'd0, lsu_req_ready}, {63'd0, v.exp_lsu});
    e.lsu = v.exp_lsu;  e.rdata = v.exp_rdata;  e.err = v.exp_err;
    sb.push_back(e);
    next_neg();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_wdata = $urandom;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int waited;
    $display("txn %0d: ifu_v=%0d lsu_v=%0d stall=%0d lat=%0d", idx, v.iv, v.lv, v.stall, v.lat);
    accept(v);
    check_req_fields(v);
    for (int s = 0; s < int'(v.stall); s++) begin
      next_neg();
      check_req_fields(v);
    end
    mem_req_ready = 1'b1;
    next_neg();
    mem_req_ready = 1'b0;
    chk("req_dropped", {63'd0, mem_req_valid}, 64'd0);
    if (int'(v.lat) < TIMEOUT) begin
      for (int s = 0; s < int'(v.lat); s++) next_neg();
      chk("no_early_resp", sb.size(), 64'd1);
      mem_resp_valid = 1'b1;
      mem_rdata = v.rdata;
      next_neg();
      mem_resp_valid = 1'b0;
      mem_rdata = $urandom;
      chk("resp_latency", sb.size(), 64'd0);
    end else begin
      waited = 1;
      while (sb.size() != 0 && waited < 200) begin
        next_neg();
        waited++;
      end
      chk("timeout_cycles", waited, TIMEOUT + 1);
      mem_resp_valid = 1'b1;
      mem_rdata = 32'h7777_7777;
      next_neg();
      mem_resp_valid = 1'b0;
      next_neg();
      chk("late_resp_ignored", {63'd0, mem_req_valid}, 64'd0);
      chk("late_resp_rdata_held", {32'd0, resp_rdata}, 64'd0);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic lv, input logic [31:0] iaddr,
                              input logic [31:0] laddr, input logic wen, input logic [31:0] wdata,
                              input logic [7:0] wmask, input logic [7:0] stall, input logic [7:0] lat,
                              input logic [31:0] rdata, input logic exp_lsu,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.iv = iv; v.lv = lv; v.iaddr = iaddr; v.laddr = laddr; v.wen = wen;
    v.wdata = wdata; v.wmask = wmask; v.stall = stall; v.lat = lat; v.rdata = rdata;
    v.exp_lsu = exp_lsu; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    vec_t v;
    vecs[0] = mk(1, 0, 32'h8000_0000, 32'h0,         0, 32'h0,         8'h00, 0, 0,   32'h0010_0093, 0, 32'h0010_0093, 0);
    vecs[1] = mk(1, 1, 32'h8000_0004, 32'h8000_0200, 0, 32'h0,         8'hFF, 0, 0,   32'h1111_1111, 1, 32'h1111_1111, 0);
    vecs[2] = mk(1, 1, 32'h8000_0004, 32'h8000_0204, 0, 32'h0,         8'hFF, 0, 1,   32'h2222_2222, 0, 32'h2222_2222, 0);
    vecs[3] = mk(1, 1, 32'h8000_0008, 32'h8000_0208, 0, 32'h0,         8'hFF, 1, 0,   32'h3333_3333, 1, 32'h3333_3333, 0);
    vecs[4] = mk(1, 1, 32'h8000_0008, 32'h8000_020C, 1, 32'h5555_AAAA, 8'hF0, 0, 0,   32'h4444_4444, 0, 32'h4444_4444, 0);
    vecs[5] = mk(0, 1, 32'h0,         32'h8000_0100, 1, 32'hDEAD_BEEF, 8'h0F, 3, 0,   32'h1234_5678, 1, 32'h0,         0);
    vecs[6] = mk(0, 1, 32'h0,         32'h8000_0300, 0, 32'h0,         8'h03, 0, 2,   32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0);
    vecs[7] = mk(1, 0, 32'h8000_0010, 32'h0,         0, 32'h0,         8'h00, 0, 99,  32'h9999_9999, 0, 32'h0,         1);
    vecs[8] = mk(0, 1, 32'h0,         32'h8000_0400, 0, 32'h0,         8'hFF, 1, 63,  32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, 0);
    vecs[9] = mk(1, 0, 32'h8000_0014, 32'h0,         0, 32'h0,         8'h00, 2, 62,  32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0);

    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_addr = 0;
    lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    repeat (3) next_neg();
    chk("reset_outputs", {30'd0, ifu_resp_valid, lsu_resp_valid, resp_err, mem_req_valid, mem_wen, mem_wmask, ifu_req_ready, lsu_req_ready},
        64'd0);
    chk("reset_data", {resp_rdata | mem_wdata, mem_addr}, 64'd0);
    rst = 1'b0;
    next_neg();

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while an LSU load sits in RESP: aborted, no response, rr back to LSU
    $display("txn reset-abort");
    v = mk(0, 1, 32'h0, 32'h8000_0500, 0, 32'h0, 8'hFF, 0, 0, 32'h0, 1, 32'h0, 0);
    accept(v);
    mem_req_ready = 1'b1;
    next_neg();
    mem_req_ready = 1'b0;
    next_neg();
    rst = 1'b1;
    sb.delete();
    next_neg();
    chk("rst_resp_outputs", {30'd0, ifu_resp_valid, lsu_resp_valid, resp_err, mem_req_valid, mem_wen, mem_wmask, ifu_req_ready, lsu_req_ready},
        64'd0);
    chk("rst_data", {resp_rdata | mem_wdata, mem_addr}, 64'd0);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h6666_6666;
    next_neg();
    mem_resp_valid = 1'b0;
    next_neg();
    run_vec(10, mk(1, 1, 32'h8000_0020, 32'h8000_0600, 0, 32'h0, 8'hFF, 0, 0, 32'h1357_9BDF, 1, 32'h1357_9BDF, 0));
    run_vec(11, mk(1, 0, 32'h8000_0024, 32'h0, 0, 32'h0, 8'h00, 0, 0, 32'h0020_0113, 0, 32'h0020_0113, 0));
    repeat (3) next_neg();
    chk("sb_drained", sb.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
